// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave front end.
//   Idle levels of the three pins (also the reset values of their conditioned levels)
//   and the default conditioning parameters.
package spi_pkg;

    localparam logic CS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

    localparam int WAIT_TIME_DEF     = 3;
    localparam int COUNTER_WIDTH_DEF = 3;
    localparam int SYNC_STAGES_DEF   = 2;

endpackage : spi_pkg

// File: rtl/spi_input_conditioner_ch.sv
// One conditioning channel: synchroniser, stability counter, edge strobes.
//   clk, rst_n  system clock / async active-low reset
//   pin         raw asynchronous input
//   cond        debounced level (resets to RESET_VAL)
//   posedge_o   one-cycle strobe after cond goes 0->1
//   negedge_o   one-cycle strobe after cond goes 1->0
module input_conditioner_ch
    import spi_pkg::*;
#(
    parameter int   WAIT_TIME     = WAIT_TIME_DEF,
    parameter int   COUNTER_WIDTH = COUNTER_WIDTH_DEF,
    parameter int   SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic cond,
    output logic posedge_o,
    output logic negedge_o
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(WAIT_TIME - 1);

    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     cond_q, cond_d;
    logic                     pos_q, pos_d;
    logic                     neg_q, neg_d;
    logic                     sync;

    // Oldest stage of the synchroniser chain is the only one used downstream.
    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
        cond_d = cond_q;
        cnt_d  = cnt_q;
        pos_d  = 1'b0;
        neg_d  = 1'b0;
        if (sync == cond_q) begin
            // Any return to the accepted level restarts the stability window.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Counter stops here, so it never wraps.
            cond_d = sync;
            cnt_d  = '0;
            pos_d  = sync;
            neg_d  = ~sync;
        end else begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            cnt_q  <= '0;
            cond_q <= RESET_VAL;
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            cond_q <= cond_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
        end
    end

    assign cond      = cond_q;
    assign posedge_o = pos_q;
    assign negedge_o = neg_q;

endmodule : input_conditioner_ch

// File: rtl/spi_input_conditioner.sv
// SPI slave input front end: conditions sclk, cs and mosi into the clk domain.
//   clk, rst_n                  system clock / async active-low reset
//   sclk_pin, cs_pin, mosi_pin  raw pins (cs active low)
//   sclk_cond, cs_cond, mosi_cond  debounced levels
//   sclk_posedge/negedge        sclk strobes, only while in a frame
//   cs_posedge/negedge          frame end / frame start strobes
module spi_input_conditioner
    import spi_pkg::*;
#(
    parameter int WAIT_TIME     = WAIT_TIME_DEF,
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic mosi_pin,
    output logic sclk_cond,
    output logic sclk_posedge,
    output logic sclk_negedge,
    output logic cs_cond,
    output logic cs_posedge,
    output logic cs_negedge,
    output logic mosi_cond
);

    logic sclk_pos_raw, sclk_neg_raw;
    logic mosi_pos_unused, mosi_neg_unused;

    input_conditioner_ch #(
        .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH),
        .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)
    ) u_sclk (
        .clk(clk), .rst_n(rst_n), .pin(sclk_pin), .cond(sclk_cond),
        .posedge_o(sclk_pos_raw), .negedge_o(sclk_neg_raw)
    );

    input_conditioner_ch #(
        .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH),
        .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)
    ) u_cs (
        .clk(clk), .rst_n(rst_n), .pin(cs_pin), .cond(cs_cond),
        .posedge_o(cs_posedge), .negedge_o(cs_negedge)
    );

    input_conditioner_ch #(
        .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH),
        .SYNC_STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)
    ) u_mosi (
        .clk(clk), .rst_n(rst_n), .pin(mosi_pin), .cond(mosi_cond),
        .posedge_o(mosi_pos_unused), .negedge_o(mosi_neg_unused)
    );

    // Raw sclk strobes and cs_cond are registered on the same edge, so cs_cond here
    // is the cs level that edge produced: a frame opening on that edge lets the
    // strobe through, a frame closing on it suppresses it.
    assign sclk_posedge = sclk_pos_raw & ~cs_cond;
    assign sclk_negedge = sclk_neg_raw & ~cs_cond;

endmodule : spi_input_conditioner
